// File: rtl/oh_standby_pkg.sv
// Shared definitions for the standby controller: FSM state encodings.
package oh_standby_pkg;

  localparam int unsigned ST_W = 2;

  // Encoding 2'd3 is illegal; the FSM recovers from it to ST_ACTIVE.
  typedef enum logic [ST_W-1:0] {
    ST_ACTIVE = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SLEEP  = 2'd2
  } state_t;

endpackage

// File: rtl/oh_clockgate.sv
// Latch-based clock gate.
//   clk  : free-running input clock
//   en   : functional enable
//   te   : test enable (forces the clock on)
//   eclk : gated clock output
module oh_clockgate (
  input  logic clk,
  input  logic en,
  input  logic te,
  output logic eclk
);

  logic en_lat;

  // Enable is captured while clk is low so eclk cannot glitch while clk is high.
  always_latch begin
    if (!clk) en_lat = en | te;
  end

  assign eclk = clk & en_lat;

endmodule

// File: rtl/oh_standby_wakedet.sv
// Wake-up event detector: per-channel edge/level selection and masking.
//   clk       : free-running clock
//   reset     : asynchronous active-high reset
//   wakeup    : raw wake-up inputs
//   wake_mask : 1 = channel may raise an event
//   wake_edge : 1 = rising-edge mode, 0 = level mode
//   ev        : per-channel event (combinational)
//   wake_now  : OR of all events (combinational)
module oh_standby_wakedet #(
  parameter int unsigned N = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] wakeup,
  input  logic [N-1:0] wake_mask,
  input  logic [N-1:0] wake_edge,
  output logic [N-1:0] ev,
  output logic         wake_now
);

  logic [N-1:0] hist;

  // History follows the raw input regardless of mask, so unmasking a channel
  // that is already high does not look like a fresh edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist <= '0;
    else       hist <= wakeup;
  end

  always_comb begin
    ev = wake_mask & ((wake_edge & wakeup & ~hist) | (~wake_edge & wakeup));
  end

  assign wake_now = |ev;

endmodule

// File: rtl/oh_standby_ctrl.sv
// Standby controller: ACTIVE/HOLD/SLEEP FSM with programmable hold-off,
// sticky wake-source reporting and core clock gating.
//   clkin        : free-running clock (all registers run on it)
//   reset        : asynchronous active-high reset
//   wakeup       : wake-up event vector
//   wake_mask    : per-channel enable
//   wake_edge    : per-channel mode (1 edge, 0 level)
//   idle         : core idle indication
//   force_on     : debug override keeping the clock running
//   hold_cycles  : clocked cycles to remain in HOLD before sleeping
//   wake_src_clr : per-bit clear of wake_src
//   clkout       : gated core clock
//   clk_en       : clock-gate enable (combinational)
//   state        : current FSM state
//   sleeping     : registered SLEEP indication
//   wake_src     : sticky record of masked wake events
module oh_standby_ctrl
  import oh_standby_pkg::*;
#(
  parameter int unsigned N  = 5,
  parameter int unsigned CW = 8
) (
  input  logic          clkin,
  input  logic          reset,
  input  logic [N-1:0]  wakeup,
  input  logic [N-1:0]  wake_mask,
  input  logic [N-1:0]  wake_edge,
  input  logic          idle,
  input  logic          force_on,
  input  logic [CW-1:0] hold_cycles,
  input  logic [N-1:0]  wake_src_clr,
  output logic          clkout,
  output logic          clk_en,
  output logic [1:0]    state,
  output logic          sleeping,
  output logic [N-1:0]  wake_src
);

  logic [N-1:0]  ev;
  logic          wake_now;
  logic          busy;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  oh_standby_wakedet #(.N(N)) u_wakedet (
    .clk       (clkin),
    .reset     (reset),
    .wakeup    (wakeup),
    .wake_mask (wake_mask),
    .wake_edge (wake_edge),
    .ev        (ev),
    .wake_now  (wake_now)
  );

  assign busy = wake_now | ~idle | force_on;

  // State, hold counter, registered sleep flag and sticky wake source.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ACTIVE;
      cnt_q    <= '0;
      sleeping <= 1'b0;
      wake_src <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sleeping <= (state_d == ST_SLEEP);
      wake_src <= ev | (wake_src & ~wake_src_clr);
    end
  end

  // Next-state and hold counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ACTIVE: begin
        if (!busy) begin
          if (hold_cycles != '0) begin
            state_d = ST_HOLD;
            cnt_d   = CW'(hold_cycles - CW'(1));
          end else begin
            state_d = ST_SLEEP;
          end
        end
      end
      ST_HOLD: begin
        if (busy) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_SLEEP;
        end else begin
          cnt_d = CW'(cnt_q - CW'(1));
        end
      end
      ST_SLEEP: begin
        if (busy) state_d = ST_ACTIVE;
      end
      default: begin
        state_d = ST_ACTIVE;
        cnt_d   = '0;
      end
    endcase
  end

  // Combinational so a wake event re-opens the gate in the cycle it arrives.
  assign clk_en = (state_q != ST_SLEEP) | busy;
  assign state  = 2'(state_q);

  oh_clockgate u_clockgate (
    .clk  (clkin),
    .en   (clk_en),
    .te   (1'b0),
    .eclk (clkout)
  );

endmodule

// File: tb/tb_oh_standby_ctrl.sv
module tb_oh_standby_ctrl;

  localparam int unsigned N  = 5;
  localparam int unsigned CW = 8;
  localparam int A = 0, H = 1, S = 2;

  logic          clkin = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  wakeup = '0, wake_mask = '0, wake_edge = '0, wake_src_clr = '0;
  logic          idle = 1'b1, force_on = 1'b0;
  logic [CW-1:0] hold_cycles = 8'd4;
  logic          clkout, clk_en, sleeping;
  logic [1:0]    state;
  logic [N-1:0]  wake_src;

  int n_cmp = 0;
  int n_bad = 0;
  int clkout_cnt = 0;

  oh_standby_ctrl #(.N(N), .CW(CW)) dut (
    .clkin(clkin), .reset(reset), .wakeup(wakeup), .wake_mask(wake_mask),
    .wake_edge(wake_edge), .idle(idle), .force_on(force_on),
    .hold_cycles(hold_cycles), .wake_src_clr(wake_src_clr),
    .clkout(clkout), .clk_en(clk_en), .state(state), .sleeping(sleeping),
    .wake_src(wake_src)
  );

  always #5 clkin = ~clkin;
  always @(posedge clkout) clkout_cnt++;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check clk_en before the edge, registers after it.
  task automatic row(input string name, input logic [N-1:0] wk, msk, edg,
                     input logic idl, frc, input logic [CW-1:0] hc,
                     input logic [N-1:0] clr, input int exp_en, exp_st,
                     input int exp_src);
    @(negedge clkin);
    wakeup = wk; wake_mask = msk; wake_edge = edg; idle = idl;
    force_on = frc; hold_cycles = hc; wake_src_clr = clr;
    #1;
    chk({name, ".clk_en"}, int'(clk_en), exp_en);
    @(posedge clkin); #1;
    chk({name, ".state"}, int'(state), exp_st);
    chk({name, ".sleeping"}, int'(sleeping), (exp_st == S) ? 1 : 0);
    chk({name, ".wake_src"}, int'(wake_src), exp_src);
  endtask

  task automatic do_reset();
    @(negedge clkin);
    reset = 1'b1;
    #1;
    chk("rst.clk_en", int'(clk_en), 1);
    chk("rst.state", int'(state), A);
    chk("rst.sleeping", int'(sleeping), 0);
    chk("rst.wake_src", int'(wake_src), 0);
    repeat (2) @(posedge clkin);
    #2 reset = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]  wk, msk, edg;
    logic          idl, frc;
    logic [CW-1:0] hc;
    logic [N-1:0]  clr;
    int            en, st, src;
  } vec_t;

  vec_t tbl[15];

  // Reference model: mode, cycles left in HOLD, previous inputs, sticky sources.
  int           m_mode, m_left;
  logic [N-1:0] m_prev, m_src;

  task automatic rnd_step(input int idx);
    logic [N-1:0] evm;
    bit busy;
    int exp_en;
    @(negedge clkin);
    if ($urandom_range(0, 15) == 0) wake_mask = N'($urandom);
    if ($urandom_range(0, 15) == 0) wake_edge = N'($urandom);
    for (int i = 0; i < N; i++) wakeup[i] = ($urandom_range(0, 6) == 0);
    for (int i = 0; i < N; i++) wake_src_clr[i] = ($urandom_range(0, 4) == 0);
    idle        = ($urandom_range(0, 7) != 0);
    force_on    = ($urandom_range(0, 30) == 0);
    hold_cycles = CW'($urandom_range(0, 5));
    #1;
    evm = '0;
    for (int i = 0; i < N; i++)
      if (wake_mask[i] && wakeup[i] && (!wake_edge[i] || !m_prev[i])) evm[i] = 1'b1;
    busy   = (evm != '0) || !idle || force_on;
    exp_en = (m_mode != S || busy) ? 1 : 0;
    chk($sformatf("rnd%0d.clk_en", idx), int'(clk_en), exp_en);
    case (m_mode)
      A: if (!busy) begin
           if (hold_cycles > 0) begin m_mode = H; m_left = int'(hold_cycles); end
           else m_mode = S;
         end
      H: if (busy) m_mode = A;
         else if (m_left == 1) m_mode = S;
         else m_left--;
      default: if (busy) m_mode = A;
    endcase
    for (int i = 0; i < N; i++)
      m_src[i] = evm[i] ? 1'b1 : (wake_src_clr[i] ? 1'b0 : m_src[i]);
    m_prev = wakeup;
    @(posedge clkin); #1;
    chk($sformatf("rnd%0d.state", idx), int'(state), m_mode);
    chk($sformatf("rnd%0d.sleeping", idx), int'(sleeping), (m_mode == S) ? 1 : 0);
    chk($sformatf("rnd%0d.wake_src", idx), int'(wake_src), int'(m_src));
  endtask

  initial begin : main
    int c0;
    // Basic sequence: hold-off of 4, wake on channel 2, clear priority, hold 0, masking, force_on.
    tbl[0]  = '{5'h00, 5'h00, 5'h00, 1, 0, 8'd4, 5'h00, 1, H, 0};
    tbl[1]  = '{5'h00, 5'h00, 5'h00, 1, 0, 8'd4, 5'h00, 1, H, 0};
    tbl[2]  = '{5'h00, 5'h00, 5'h00, 1, 0, 8'd4, 5'h00, 1, H, 0};
    tbl[3]  = '{5'h00, 5'h00, 5'h00, 1, 0, 8'd4, 5'h00, 1, H, 0};
    tbl[4]  = '{5'h00, 5'h00, 5'h00, 1, 0, 8'd4, 5'h00, 1, S, 0};
    tbl[5]  = '{5'h00, 5'h00, 5'h00, 1, 0, 8'd4, 5'h00, 0, S, 0};
    tbl[6]  = '{5'h04, 5'h04, 5'h04, 1, 0, 8'd4, 5'h00, 1, A, 4};
    tbl[7]  = '{5'h00, 5'h04, 5'h04, 1, 0, 8'd4, 5'h00, 1, H, 4};
    tbl[8]  = '{5'h04, 5'h04, 5'h04, 1, 0, 8'd4, 5'h04, 1, A, 4};
    tbl[9]  = '{5'h00, 5'h04, 5'h04, 1, 0, 8'd4, 5'h04, 1, H, 0};
    tbl[10] = '{5'h00, 5'h04, 5'h04, 0, 0, 8'd0, 5'h00, 1, A, 0};
    tbl[11] = '{5'h00, 5'h04, 5'h04, 1, 0, 8'd0, 5'h00, 1, S, 0};
    tbl[12] = '{5'h01, 5'h04, 5'h04, 1, 0, 8'd0, 5'h00, 0, S, 0};
    tbl[13] = '{5'h01, 5'h04, 5'h04, 1, 1, 8'd0, 5'h00, 1, A, 0};
    tbl[14] = '{5'h00, 5'h04, 5'h04, 1, 0, 8'd0, 5'h00, 1, S, 0};

    do_reset();
    for (int i = 0; i < 15; i++)
      row($sformatf("tbl%0d", i), tbl[i].wk, tbl[i].msk, tbl[i].edg, tbl[i].idl,
          tbl[i].frc, tbl[i].hc, tbl[i].clr, tbl[i].en, tbl[i].st, tbl[i].src);

    // Gated clock stays quiet in SLEEP.
    c0 = clkout_cnt;
    for (int i = 0; i < 4; i++) row("slp", 0, 0, 0, 1, 0, 8'd3, 0, 0, S, 0);
    chk("clkout_quiet", clkout_cnt - c0, 0);

    // Level-mode channel 0 held high keeps ACTIVE; then HOLD 3 cycles, SLEEP.
    c0 = clkout_cnt;
    for (int i = 0; i < 20; i++) row("lvl", 5'h01, 5'h01, 5'h00, 1, 0, 8'd3, 0, 1, A, 1);
    chk("clkout_running", (clkout_cnt - c0 >= 19) ? 1 : 0, 1);
    row("lvl_h0", 0, 5'h01, 0, 1, 0, 8'd3, 5'h01, 1, H, 0);
    row("lvl_h1", 0, 5'h01, 0, 1, 0, 8'd3, 0, 1, H, 0);
    row("lvl_h2", 0, 5'h01, 0, 1, 0, 8'd3, 0, 1, H, 0);
    row("lvl_s",  0, 5'h01, 0, 1, 0, 8'd3, 0, 1, S, 0);
    row("lvl_s2", 0, 5'h01, 0, 1, 0, 8'd3, 0, 0, S, 0);

    // Hold 6 interrupted at count 2, then full reload; hold_cycles change in HOLD ignored.
    row("ho_wake", 0, 0, 0, 1, 1, 8'd6, 0, 1, A, 0);
    row("ho_h1",   0, 0, 0, 1, 0, 8'd6, 0, 1, H, 0);
    row("ho_h2",   0, 0, 0, 1, 0, 8'd6, 0, 1, H, 0);
    row("ho_drop", 0, 0, 0, 0, 0, 8'd6, 0, 1, A, 0);
    row("ho_r0",   0, 0, 0, 1, 0, 8'd6, 0, 1, H, 0);
    for (int i = 0; i < 5; i++) row("ho_r", 0, 0, 0, 1, 0, 8'd1, 0, 1, H, 0);
    row("ho_s",    0, 0, 0, 1, 0, 8'd1, 0, 1, S, 0);
    row("ho_frc",  0, 0, 0, 1, 1, 8'd1, 0, 1, A, 0);

    // Reset mid-SLEEP, then channel 3 high across reset release gives one event.
    row("rs_ev",  5'h08, 5'h08, 5'h08, 1, 0, 8'd0, 0, 1, A, 8);
    row("rs_slp", 5'h00, 5'h08, 5'h08, 1, 0, 8'd0, 0, 1, S, 8);
    wakeup = 5'h08;
    do_reset();
    row("rs_rel", 5'h08, 5'h08, 5'h08, 1, 0, 8'd0, 0, 1, A, 8);
    row("rs_clr", 5'h08, 5'h08, 5'h08, 1, 0, 8'd0, 5'h08, 1, S, 0);
    row("rs_one", 5'h08, 5'h08, 5'h08, 1, 0, 8'd0, 0, 0, S, 0);

    // Unmasking a channel already high produces no event.
    row("unm0", 5'h02, 5'h00, 5'h02, 1, 0, 8'd0, 0, 0, S, 0);
    row("unm1", 5'h02, 5'h02, 5'h02, 1, 0, 8'd0, 0, 0, S, 0);

    // Randomized run against the reference model.
    wakeup = '0; wake_mask = 5'h1f; wake_edge = 5'h0a; wake_src_clr = '0;
    do_reset();
    m_mode = A; m_left = 0; m_prev = '0; m_src = '0;
    for (int i = 0; i < 1500; i++) rnd_step(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
